// File: rtl/rgb_led_pkg.sv
// Shared types and constants for the RGB LED arbiter.
package rgb_led_pkg;

    localparam int RGB_W = 24;

    localparam logic [RGB_W-1:0] RGB_OFF    = 24'h000000;
    localparam logic [RGB_W-1:0] RGB_RED    = 24'hFF0000;
    localparam logic [RGB_W-1:0] RGB_GREEN  = 24'h00FF00;
    localparam logic [RGB_W-1:0] RGB_BLUE   = 24'h0000FF;
    localparam logic [RGB_W-1:0] RGB_ORANGE = 24'hFFA050;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rgb_led_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module rgb_led_prio_enc #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        // Walk from lowest priority upward so the highest-priority hit lands last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Fixed-priority RGB LED sharer with minimum display hold.
// Define RGB_LED_ARB_PREEMPT_EN to let higher-priority requests preempt before hold expiry.
module rgb_led_arbiter
    import rgb_led_pkg::*;
#(
    parameter int               NUM_REQ     = 4,
    parameter int               HOLD_CYCLES = 1000,
    parameter logic [RGB_W-1:0] IDLE_RGB    = 24'h000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [RGB_W*NUM_REQ-1:0] req_rgb,
    input  logic [NUM_REQ-1:0]       req_blink,
    output logic [NUM_REQ-1:0]       grant,
    output logic [RGB_W-1:0]         rgb,
    output logic                     blink_en,
    output logic                     busy
);

    localparam int          IDX_W       = $clog2(NUM_REQ);
    localparam logic [31:0] HOLD_RELOAD = 32'(HOLD_CYCLES - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               blink_q, blink_d;
    logic [31:0]        hold_cnt_q, hold_cnt_d;

    logic [NUM_REQ-1:0] enc_onehot;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic               take_new, go_idle;
    logic               hold_done, owner_req;
    logic [RGB_W-1:0]   owner_rgb, win_rgb;

    rgb_led_prio_enc #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req    (req),
        .onehot (enc_onehot),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    assign hold_done = (hold_cnt_q == 32'd0);
    assign owner_req = req[owner_q];
    assign owner_rgb = req_rgb[RGB_W*int'(owner_q) +: RGB_W];
    assign win_rgb   = req_rgb[RGB_W*int'(enc_idx) +: RGB_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rgb_q      <= IDLE_RGB;
            blink_q    <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rgb_q      <= rgb_d;
            blink_q    <= blink_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Arbitration decisions: grant a new owner, drop to idle, or keep the current one.
    always_comb begin
        state_d  = state_q;
        take_new = 1'b0;
        go_idle  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    take_new = 1'b1;
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (hold_done) begin
                    if (!enc_valid) begin
                        go_idle = 1'b1;
                        state_d = ST_IDLE;
                    end else if (enc_idx != owner_q) begin
                        take_new = 1'b1;
                    end
                end
`ifdef RGB_LED_ARB_PREEMPT_EN
                if (enc_valid && (enc_idx < owner_q)) begin
                    take_new = 1'b1;
                    go_idle  = 1'b0;
                    state_d  = ST_SHOW;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d    = grant_q;
        owner_d    = owner_q;
        rgb_d      = rgb_q;
        blink_d    = blink_q;
        hold_cnt_d = hold_done ? 32'd0 : hold_cnt_q - 32'd1;
        // A dropped owner leaves its last colour frozen on the LED.
        if (state_q == ST_SHOW && owner_req) begin
            rgb_d   = owner_rgb;
            blink_d = req_blink[owner_q];
        end
        if (take_new) begin
            grant_d    = enc_onehot;
            owner_d    = enc_idx;
            rgb_d      = win_rgb;
            blink_d    = req_blink[enc_idx];
            hold_cnt_d = HOLD_RELOAD;
        end else if (go_idle) begin
            grant_d    = '0;
            owner_d    = '0;
            rgb_d      = IDLE_RGB;
            blink_d    = 1'b0;
            hold_cnt_d = '0;
        end
    end

    always_comb begin
        grant    = grant_q;
        rgb      = rgb_q;
        blink_en = blink_q;
        busy     = (state_q == ST_SHOW);
    end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Scoreboard bench for rgb_led_arbiter: directed test-plan sequences plus random traffic.
module tb_rgb_led_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam logic [23:0] IDLE_C = 24'h000000;

    typedef struct {
        logic [N-1:0] grant;
        logic [23:0]  rgb;
        logic         blink;
        logic         busy;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [24*N-1:0] req_rgb = '0;
    logic [N-1:0]    req_blink = '0;
    logic [N-1:0]    grant;
    logic [23:0]     rgb;
    logic            blink_en;
    logic            busy;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // Reference model: owner (-1 = none), edge number of grant, displayed colour.
    int          m_owner = -1;
    int          m_start = 0;
    int          m_cyc   = 0;
    logic [23:0] m_rgb   = IDLE_C;
    logic        m_blink = 1'b0;

    rgb_led_arbiter #(
        .NUM_REQ     (N),
        .HOLD_CYCLES (HOLD),
        .IDLE_RGB    (IDLE_C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rgb   (req_rgb),
        .req_blink (req_blink),
        .grant     (grant),
        .rgb       (rgb),
        .blink_en  (blink_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input exp_t e);
        checks++;
        if (grant !== e.grant || rgb !== e.rgb || blink_en !== e.blink || busy !== e.busy) begin
            errors++;
            $display("FAIL %s t=%0t got grant=%b rgb=%h blink=%b busy=%b want grant=%b rgb=%h blink=%b busy=%b",
                     name, $time, grant, rgb, blink_en, busy, e.grant, e.rgb, e.blink, e.busy);
        end
    endtask

    // Monitor: every edge the DUT presents a new output word; compare it against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                compare("cycle", e);
            end
        end
    end

    task automatic model_take(input int v, input logic [24*N-1:0] c, input logic [N-1:0] b);
        m_owner = v;
        m_start = m_cyc;
        m_rgb   = c[24*v +: 24];
        m_blink = b[v];
    endtask

    // Apply inputs for one edge, step the model and push the expected response.
    task automatic cycle(input logic [N-1:0] r, input logic [24*N-1:0] c, input logic [N-1:0] b);
        int   lo;
        bit   expired;
        exp_t e;
        @(negedge clk);
        req = r; req_rgb = c; req_blink = b;
        m_cyc++;
        lo = -1;
        for (int i = N - 1; i >= 0; i--) if (r[i]) lo = i;
        if (m_owner < 0) begin
            if (lo >= 0) model_take(lo, c, b);
        end else begin
            expired = (m_cyc - m_start) >= HOLD;
            if (r[m_owner]) begin
                m_rgb   = c[24*m_owner +: 24];
                m_blink = b[m_owner];
            end
`ifdef RGB_LED_ARB_PREEMPT_EN
            if (lo >= 0 && lo < m_owner) model_take(lo, c, b);
            else
`endif
            if (expired) begin
                if (lo < 0) begin
                    m_owner = -1;
                    m_rgb   = IDLE_C;
                    m_blink = 1'b0;
                end else if (lo != m_owner) begin
                    model_take(lo, c, b);
                end
            end
        end
        e.grant = (m_owner < 0) ? '0 : N'(1 << m_owner);
        e.rgb   = (m_owner < 0) ? IDLE_C : m_rgb;
        e.blink = (m_owner < 0) ? 1'b0 : m_blink;
        e.busy  = (m_owner >= 0);
        q.push_back(e);
    endtask

    task automatic repeat_cycle(input int n, input logic [N-1:0] r, input logic [24*N-1:0] c,
                                input logic [N-1:0] b);
        for (int i = 0; i < n; i++) cycle(r, c, b);
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.grant = '0; e.rgb = IDLE_C; e.blink = 1'b0; e.busy = 1'b0;
        return e;
    endfunction

    initial begin
        logic [24*N-1:0] c;
        logic [N-1:0]    r, b;
        logic [23:0]     pal [0:4];
        pal[0] = 24'hFF0000; pal[1] = 24'h00FF00; pal[2] = 24'h0000FF;
        pal[3] = 24'hFFA050; pal[4] = 24'h123456;

        repeat (3) @(posedge clk);
        @(negedge clk);
        compare("reset", reset_exp());
        rst = 1'b0;

        repeat_cycle(5, 4'b0000, '0, '0);

        c = '0; c[48 +: 24] = 24'h00FF00;
        repeat_cycle(3, 4'b0100, c, 4'b0100);
        c[48 +: 24] = 24'h0000FF;
        repeat_cycle(10, 4'b0100, c, 4'b0100);
        repeat_cycle(10, 4'b0000, c, '0);

        c = {24'hFFA050, 24'h0, 24'h0, 24'hFF0000};
        repeat_cycle(2, 4'b1001, c, 4'b1000);
        repeat_cycle(12, 4'b1000, c, 4'b1000);
        repeat_cycle(10, 4'b0000, c, '0);

        c = {24'h0000FF, 24'h0, 24'h0, 24'h00FF00};
        repeat_cycle(2, 4'b1000, c, 4'b0001);
        repeat_cycle(12, 4'b1001, c, 4'b0001);
        repeat_cycle(10, 4'b0000, c, '0);

        c = '0; c[24 +: 24] = 24'hFF0000;
        cycle(4'b0010, c, 4'b0000);
        repeat_cycle(12, 4'b0000, c, '0);

        // Asynchronous reset in the middle of a SHOW window.
        repeat_cycle(3, 4'b0010, c, 4'b0010);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 compare("async_reset", reset_exp());
        m_owner = -1; m_rgb = IDLE_C; m_blink = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("reset_held", reset_exp());
        rst = 1'b0;
        repeat_cycle(6, 4'b0000, c, '0);

        r = '0; b = '0; c = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom & $urandom);
            if ($urandom_range(0, 2) == 0) b = N'($urandom);
            if ($urandom_range(0, 1) == 0) c[24*$urandom_range(0, N-1) +: 24] = pal[$urandom_range(0, 4)];
            cycle(r, c, b);
        end
        repeat_cycle(20, 4'b0000, c, '0);

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
